// File: rtl/nibble_serial_compare_ctrl.sv
// Nibble-serial magnitude compare sequencer: drives one shared 4-bit comparator
// slice MSB nibble first and stops on the first unequal nibble.
module nibble_serial_compare_ctrl #(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / 4,
    localparam int CW    = $clog2(NIB) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    output logic [3:0]       CMP_A,
    output logic [3:0]       CMP_B,
    input  logic             CMP_EQ,
    input  logic             CMP_LT,
    input  logic             CMP_GT,
    output logic             BUSY,
    output logic             DONE,
    output logic             EQ,
    output logic             LT,
    output logic             GT,
    output logic [CW-1:0]    NCYC
);

    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [1:0] V_EQ = 2'd0;
    localparam logic [1:0] V_LT = 2'd1;
    localparam logic [1:0] V_GT = 2'd2;

    localparam logic [IW-1:0] IDX_TOP  = IW'(NIB - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [CW-1:0] NCYC_ONE = CW'(1);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IW-1:0]    idx_r;
    logic [3:0]       cmp_a_r;
    logic [3:0]       cmp_b_r;
    logic             busy_r;
    logic             done_r;
    logic             eq_r;
    logic             lt_r;
    logic             gt_r;
    logic [CW-1:0]    ncyc_r;

    logic [1:0]       verdict_s;
    logic             last_s;
    logic [IW-1:0]    idx_dec_s;

    function automatic logic [3:0] nib_sel(input logic [WIDTH-1:0] vec, input logic [IW-1:0] sel);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 0; k < NIB; k++) begin
            if (sel == IW'(k)) r = vec[k*4 +: 4];
        end
        return r;
    endfunction

    // Resolve the slice outputs by priority GT > LT > EQ; no asserted code counts as equal
    always_comb begin
        verdict_s = V_EQ;
        casez ({CMP_GT, CMP_LT, CMP_EQ})
            3'b1??:  verdict_s = V_GT;
            3'b01?:  verdict_s = V_LT;
            3'b001:  verdict_s = V_EQ;
            3'b000:  verdict_s = V_EQ;
            default: verdict_s = V_EQ;
        endcase
        last_s    = (idx_r == {IW{1'b0}});
        idx_dec_s = idx_r - IDX_ONE;
    end

    // Sequencer state, latched operands, comparator nibbles and verdict registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            idx_r   <= {IW{1'b0}};
            cmp_a_r <= 4'h0;
            cmp_b_r <= 4'h0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            eq_r    <= 1'b0;
            lt_r    <= 1'b0;
            gt_r    <= 1'b0;
            ncyc_r  <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (START) begin
                        a_r     <= OP_A;
                        b_r     <= OP_B;
                        idx_r   <= IDX_TOP;
                        cmp_a_r <= nib_sel(OP_A, IDX_TOP);
                        cmp_b_r <= nib_sel(OP_B, IDX_TOP);
                        ncyc_r  <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    ncyc_r <= ncyc_r + NCYC_ONE;
                    if ((verdict_s != V_EQ) || last_s) begin
                        eq_r    <= (verdict_s == V_EQ);
                        lt_r    <= (verdict_s == V_LT);
                        gt_r    <= (verdict_s == V_GT);
                        cmp_a_r <= 4'h0;
                        cmp_b_r <= 4'h0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        // Preload the next nibble so the slice sees it right after this edge
                        idx_r   <= idx_dec_s;
                        cmp_a_r <= nib_sel(a_r, idx_dec_s);
                        cmp_b_r <= nib_sel(b_r, idx_dec_s);
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    cmp_a_r <= 4'h0;
                    cmp_b_r <= 4'h0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign CMP_A = cmp_a_r;
    assign CMP_B = cmp_b_r;
    assign BUSY  = busy_r;
    assign DONE  = done_r;
    assign EQ    = eq_r;
    assign LT    = lt_r;
    assign GT    = gt_r;
    assign NCYC  = ncyc_r;

endmodule

// File: tb/tb_nibble_serial_compare_ctrl.sv
// Scoreboard bench for nibble_serial_compare_ctrl: directed plus randomized compares
// checked against a whole-operand reference model, with a behavioural comparator slice.
module tb_nibble_serial_compare_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;
    localparam int CW  = $clog2(NIB) + 1;

    typedef struct {
        logic eq;
        logic lt;
        logic gt;
        int   ncyc;
        time  t_done;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [3:0]    cmp_a;
    logic [3:0]    cmp_b;
    logic          cmp_eq;
    logic          cmp_lt;
    logic          cmp_gt;
    logic          busy;
    logic          done;
    logic          eq;
    logic          lt;
    logic          gt;
    logic [CW-1:0] ncyc;

    int   cmp_mode = 0;   // 0 real comparator, 1 no code, 2 all codes, 3 LT+EQ
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t last;

    nibble_serial_compare_ctrl #(.WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .START(start), .OP_A(op_a), .OP_B(op_b),
        .CMP_A(cmp_a), .CMP_B(cmp_b), .CMP_EQ(cmp_eq), .CMP_LT(cmp_lt), .CMP_GT(cmp_gt),
        .BUSY(busy), .DONE(done), .EQ(eq), .LT(lt), .GT(gt), .NCYC(ncyc)
    );

    always #5 clk = ~clk;

    assign cmp_eq = (cmp_mode == 0) ? (cmp_a == cmp_b) : (cmp_mode != 1);
    assign cmp_lt = (cmp_mode == 0) ? (cmp_a < cmp_b)  : (cmp_mode >= 2);
    assign cmp_gt = (cmp_mode == 0) ? (cmp_a > cmp_b)  : (cmp_mode == 2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
        exp_t e;
        logic [W-1:0] x;
        e = '{eq: 1'b0, lt: 1'b0, gt: 1'b0, ncyc: NIB, t_done: 0};
        case (mode)
            1: e.eq = 1'b1;
            2: begin e.gt = 1'b1; e.ncyc = 1; end
            3: begin e.lt = 1'b1; e.ncyc = 1; end
            default: begin
                e.eq = (a == b);
                e.lt = (a < b);
                e.gt = (a > b);
                x = a ^ b;
                for (int k = NIB - 1; k >= 0; k--) begin
                    if (x[k*4 +: 4] != 4'h0) begin
                        e.ncyc = NIB - k;
                        break;
                    end
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every DONE pulse must match the oldest expected verdict and its timing
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'(0));
            end else begin
                e = sb.pop_front();
                check("verdict", {29'd0, eq, lt, gt}, {29'd0, e.eq, e.lt, e.gt});
                check("ncyc", 32'(ncyc), 32'(e.ncyc));
                check("done_time", 32'($time), 32'(e.t_done));
            end
        end
    end

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                       input bit noise, input int idle);
        exp_t e;
        int   prev;
        bit   got;
        repeat (idle) begin @(negedge clk); #1; end
        e = model(a, b, mode);
        cmp_mode = mode;
        op_a = a;
        op_b = b;
        start = 1'b1;
        @(posedge clk);
        e.t_done = $time + 10 * e.ncyc + 5;
        sb.push_back(e);
        #1;
        start = 1'b0;
        prev = done_cnt;
        got = 1'b0;
        for (int i = 0; i < NIB + 4 && !got; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != prev) begin
                got = 1'b1;
                check("busy_in_done", 32'(busy), 32'(1));
                check("cmp_a_idle", 32'(cmp_a), 32'(0));
                start = noise;
            end else begin
                check("busy_compare", 32'(busy), 32'(1));
                check("verdict_held", {29'd0, eq, lt, gt}, {29'd0, last.eq, last.lt, last.gt});
                if (i < e.ncyc) begin
                    check("ncyc_count", 32'(ncyc), 32'(i));
                    check("cmp_a_nib", 32'(cmp_a), 32'(a[(NIB-1-i)*4 +: 4]));
                    check("cmp_b_nib", 32'(cmp_b), 32'(b[(NIB-1-i)*4 +: 4]));
                end
                start = noise && (i == 0);
            end
            op_a = W'($urandom);
            op_b = W'($urandom);
        end
        if (!got) check("done_timeout", 32'(0), 32'(1));
        @(negedge clk);
        #1;
        start = 1'b0;
        check("busy_after", 32'(busy), 32'(0));
        check("done_after", 32'(done), 32'(0));
        last = e;
    endtask

    task automatic check_zero(input string name);
        check(name, {16'd0, busy, done, eq, lt, gt, cmp_a, cmp_b, 32'(ncyc) >= 32'd8 ? 1'b1 : 1'b0},
              32'd0);
        check({name, "_ncyc"}, 32'(ncyc), 32'(0));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int p;
        last = '{eq: 1'b0, lt: 1'b0, gt: 1'b0, ncyc: 0, t_done: 0};
        rst = 1'b1;
        start = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;

        run(16'h4321, 16'h4321, 0, 1'b0, 0);
        run(16'h8000, 16'h7FFF, 0, 1'b0, 1);
        run(16'h1230, 16'h1231, 0, 1'b0, 0);
        run(16'h0000, 16'hFFFF, 0, 1'b0, 2);
        run(16'h00F0, 16'h00E0, 0, 1'b1, 1);
        run(16'h5555, 16'h1111, 1, 1'b0, 0);
        run(16'h1111, 16'h5555, 2, 1'b0, 0);
        run(16'h5555, 16'h1111, 3, 1'b1, 0);

        // Reset in the second compare cycle discards the operation with no DONE
        cmp_mode = 0;
        op_a = 16'hAAAA;
        op_b = 16'hAAAB;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_zero("mid_reset");
        repeat (6) begin @(negedge clk); #1; end
        last = '{eq: 1'b0, lt: 1'b0, gt: 1'b0, ncyc: 0, t_done: 0};
        run(16'h0001, 16'h0001, 0, 1'b0, 0);

        // Verdict hold over idle cycles, then back-to-back start
        run(16'h9000, 16'h1000, 0, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            check("hold_verdict", {29'd0, eq, lt, gt}, {29'd0, last.eq, last.lt, last.gt});
            check("hold_ncyc", 32'(ncyc), 32'(last.ncyc));
            @(negedge clk);
            #1;
        end
        run(16'h2345, 16'h2345, 0, 1'b0, 0);
        run(16'h0042, 16'h0043, 0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            a = W'($urandom);
            b = a;
            p = $urandom_range(0, NIB - 1);
            if ($urandom_range(0, 3) != 0) b[p*4 +: 4] = 4'($urandom);
            if ($urandom_range(0, 3) == 0) b = W'($urandom);
            run(a, b, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0,
                1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
